// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with a single-cycle result pulse.
module muldiv_unit #(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic              div_zero_q, div_zero_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic [XLEN-1:0]   res_q, res_d, out_q, out_d;

  // Operand decode at acceptance
  logic            signed_a, signed_b, in_neg_a, in_neg_b, in_is_div;
  logic            in_b_zero, in_ovf, early_req;
  logic [XLEN-1:0] in_a_mag, in_b_mag, early_res;
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  assign signed_a  = (i_op == 3'd1) || (i_op == 3'd2) || (i_op[2] && !i_op[0]);
  assign signed_b  = (i_op == 3'd1) || (i_op[2] && !i_op[0]);
  assign in_neg_a  = signed_a && i_a[XLEN-1];
  assign in_neg_b  = signed_b && i_b[XLEN-1];
  assign in_a_mag  = in_neg_a ? -i_a : i_a;
  assign in_b_mag  = in_neg_b ? -i_b : i_b;
  assign in_is_div = i_op[2];
  assign in_b_zero = (i_b == '0);
  assign in_ovf    = !i_op[0] && (i_a == MinInt) && (i_b == '1);
  assign early_req = in_is_div && (in_b_zero || in_ovf);
  // REM/REMU select on op[1]: b==0 gives {a, all ones}, overflow gives {0, a}
  assign early_res = in_b_zero ? (i_op[1] ? i_a : '1) : (i_op[1] ? '0 : i_a);

  // Iteration datapaths
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, a_mag_q};
  // Partial remainder with borrow bit; MSB set means the trial subtract failed
  assign div_trial = {rem_q, quo_q[XLEN-1]} - {1'b0, b_mag_q};

  assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
  assign quo_fix  = div_zero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -quo_q : quo_q);
  assign rem_fix  = neg_a_q ? -rem_q : rem_q;
  assign fix_res  = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                            : ((op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0]
                                                   : prod_fix[2*XLEN-1:XLEN]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    div_zero_d = div_zero_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    res_d      = res_q;
    out_d      = out_q;

    unique case (state_q)
      StIdle: begin
        if (i_valid && !i_flush) begin
          op_d       = i_op;
          neg_a_d    = in_neg_a;
          neg_b_d    = in_neg_b;
          div_zero_d = in_is_div && in_b_zero;
          a_mag_d    = in_a_mag;
          b_mag_d    = in_b_mag;
          prod_d     = {{XLEN{1'b0}}, in_b_mag};
          rem_d      = '0;
          quo_d      = in_a_mag;
          cnt_d      = '0;
          if (EARLY_OUT && early_req) begin
            res_d   = early_res;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (i_flush) begin
          state_d = StIdle;
        end else begin
          prod_d = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]}
                             : {1'b0, prod_q[2*XLEN-1:1]};
          if (div_trial[XLEN]) begin
            rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end else begin
            rem_d = div_trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(XLEN - 1)) state_d = StFix;
        end
      end
      StFix: begin
        if (i_flush) begin
          state_d = StIdle;
        end else begin
          res_d   = fix_res;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!i_flush) out_d = res_q;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_zero_q <= 1'b0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      res_q      <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      div_zero_q <= div_zero_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      res_q      <= res_d;
      out_q      <= out_d;
    end
  end

  assign o_ready  = (state_q == StIdle);
  assign o_valid  = (state_q == StDone) && !i_flush;
  // out_q holds the last delivered result so a flushed DONE leaves it untouched
  assign o_result = o_valid ? res_q : out_q;

endmodule
